spi_slave: RTL and testbench

- Serial front end of the SPI subsystem.
- Deserialises MOSI into 10-bit command frames for the data memory (`rx_data`/`rx_valid`).
- Captures the memory's read response (`tx_data`/`tx_valid`) and serialises it MSB-first on MISO.
- Runs on the system clock: one MOSI/MISO bit per `clk` cycle while `SS_n` is low. This makes it the counterpart of the memory's `din`/`rx_valid`/`dout`/`tx_valid` port.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_slave_if.sv | 22 ++
 rtl/spi_slave.sv | 109 ++++++++++
 tb/tb_spi_slave.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI front end: state encoding, frame width and
// the two-bit command codes carried in the top bits of every frame.
package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int FRAME_W    = SPI_DATA_W + 2;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t CHK_CMD   = 3'd1;
  localparam state_t WRITE     = 3'd2;
  localparam state_t READ_ADD  = 3'd3;
  localparam state_t READ_DATA = 3'd4;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  function automatic cmd_e frame_cmd(input logic [FRAME_W-1:0] frame);
    return cmd_e'(frame[FRAME_W-1 -: 2]);
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Serial pins plus the memory-side command/response port of the SPI slave.
interface spi_slave_if #(parameter int DATA_W = 8);

  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_slave.sv
// SPI slave clocked by the system clock: assembles MOSI into command frames
// for the data memory and serialises the memory's read response onto MISO.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_slave_if.slave bus
);

  localparam int FW    = DATA_W + 2;
  localparam int TXC_W = $clog2(DATA_W);
  localparam logic [3:0] LAST_BIT = 4'(FW - 2);
  localparam logic [3:0] DONE_CNT = 4'(FW - 1);
  localparam logic [TXC_W-1:0] TX_LAST = TXC_W'(DATA_W - 1);

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [FW-2:0]     rx_shift;
  logic [FW-1:0]     rx_data_q;
  logic              rx_valid_q;
  logic              rd_addr_seen;
  logic [DATA_W-1:0] tx_shift;
  logic [TXC_W-1:0]  tx_cnt;
  logic              tx_busy;
  logic              tx_done;
  logic              miso_q;
  logic              frame_done;

  assign frame_done   = (bit_cnt == DONE_CNT);
  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

  // Frames are assembled in rx_shift so an aborted frame never disturbs rx_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rd_addr_seen <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (state != IDLE && bus.SS_n) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
        tx_cnt   <= '0;
        tx_busy  <= 1'b0;
        tx_done  <= 1'b0;
        miso_q   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!bus.SS_n) state <= CHK_CMD;
          end
          CHK_CMD: begin
            rx_shift <= {rx_shift[FW-3:0], bus.MOSI};
            if (!bus.MOSI)        state <= WRITE;
            else if (rd_addr_seen) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!frame_done) begin
              rx_shift <= {rx_shift[FW-3:0], bus.MOSI};
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == LAST_BIT) begin
                rx_data_q  <= {rx_shift, bus.MOSI};
                rx_valid_q <= 1'b1;
                if (state == READ_ADD) rd_addr_seen <= 1'b1;
              end
            end else if (state == READ_DATA) begin
              // Only one response per read frame; later tx_valid pulses are ignored.
              if (tx_busy) begin
                miso_q   <= tx_shift[DATA_W-1];
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                tx_cnt   <= tx_cnt + TXC_W'(1);
                if (tx_cnt == TX_LAST) begin
                  tx_busy      <= 1'b0;
                  tx_done      <= 1'b1;
                  rd_addr_seen <= 1'b0;
                end
              end else if (bus.tx_valid && !tx_done) begin
                miso_q   <= bus.tx_data[DATA_W-1];
                tx_shift <= {bus.tx_data[DATA_W-2:0], 1'b0};
                tx_cnt   <= TXC_W'(1);
                tx_busy  <= 1'b1;
              end else begin
                miso_q <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: frames are scoreboarded on rx_valid and the
// read response is compared bit by bit on MISO.
module tb_spi_slave;
  import spi_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   valid_seen;
  logic [9:0] rx_q[$];
  logic       miso_q[$];
  logic [9:0] exp_frame;
  logic [7:0] rd_byte;

  spi_slave_if #(.DATA_W(8)) bus ();

  spi_slave #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each rx_valid strobe retires the oldest frame shifted in by the stimulus.
  always @(negedge clk) begin
    if (rst_n && bus.rx_valid) begin
      valid_seen++;
      if (rx_q.size() == 0) begin
        check_output("rx_unexpected", 32'(bus.rx_valid), 32'd0);
      end else begin
        exp_frame = rx_q.pop_front();
        check_output("rx_data", 32'(bus.rx_data), 32'(exp_frame));
      end
    end
  end

  task automatic apply_stimulus(input logic [9:0] frame, input bit keep_low, input int pulse_at);
    int seen;
    @(negedge clk);
    bus.SS_n = 1'b0;
    bus.MOSI = 1'b0;
    rx_q.push_back(frame);
    seen = valid_seen;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      check_output("frame_quiet", 32'({bus.MISO, bus.rx_valid}), 32'd0);
      bus.tx_valid = (i == pulse_at);
      if (i == pulse_at) bus.tx_data = 8'hA5;
      bus.MOSI = frame[i];
    end
    @(negedge clk);
    bus.tx_valid = 1'b0;
    #1;
    check_output("rx_latency", 32'(valid_seen), 32'(seen + 1));
    check_output("rx_valid_hi", 32'(bus.rx_valid), 32'd1);
    @(negedge clk);
    if (!keep_low) bus.SS_n = 1'b1;
    check_output("rx_valid_single", 32'(bus.rx_valid), 32'd0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    valid_seen = 0;
    rst_n        = 1'b0;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    #1;
    check_output("reset_miso", 32'(bus.MISO), 32'd0);
    check_output("reset_rx_data", 32'(bus.rx_data), 32'd0);
    check_output("reset_state", 32'(dut.state), 32'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] write address and write data frames");
    apply_stimulus({WR_ADDR, 8'h0A}, 1'b0, -1);
    apply_stimulus({WR_DATA, 8'h0B}, 1'b0, -1);

    $display("[TB] read address frame");
    apply_stimulus({RD_ADDR, 8'h0A}, 1'b0, -1);
    check_output("rd_addr_seen_set", 32'(dut.rd_addr_seen), 32'd1);

    $display("[TB] reset in the middle of a frame");
    @(negedge clk);
    bus.SS_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.MOSI = i[0];
    end
    @(negedge clk);
    rst_n    = 1'b0;
    bus.SS_n = 1'b1;
    #1;
    check_output("midrst_miso", 32'(bus.MISO), 32'd0);
    check_output("midrst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check_output("midrst_state", 32'(dut.state), 32'(IDLE));
    check_output("midrst_rx_data", 32'(bus.rx_data), 32'd0);
    check_output("midrst_rd_addr_seen", 32'(dut.rd_addr_seen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus({RD_ADDR, 8'h0A}, 1'b0, -1);

    $display("[TB] read data frame with memory response");
    rd_byte = 8'h0B;
    apply_stimulus(10'h3A5, 1'b1, -1);
    bus.tx_data  = rd_byte;
    bus.tx_valid = 1'b1;
    for (int i = 7; i >= 0; i--) miso_q.push_back(rd_byte[i]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.tx_valid = (i == 3);
      bus.tx_data  = (i == 3) ? 8'hF0 : rd_byte;
      check_output("miso_bit", 32'(bus.MISO), 32'(miso_q.pop_front()));
    end
    @(negedge clk);
    check_output("miso_tail", 32'(bus.MISO), 32'd0);
    check_output("rd_addr_seen_clr", 32'(dut.rd_addr_seen), 32'd0);
    bus.SS_n = 1'b1;

    $display("[TB] read data command without a prior address");
    apply_stimulus(10'h355, 1'b1, -1);
    bus.tx_data  = 8'hFF;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.tx_valid = 1'b0;
      check_output("no_read_miso", 32'(bus.MISO), 32'd0);
    end
    check_output("no_read_addr_seen", 32'(dut.rd_addr_seen), 32'd1);
    bus.SS_n = 1'b1;

    $display("[TB] aborted frame then full frame");
    @(negedge clk);
    bus.SS_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.MOSI = 1'b1;
    end
    @(negedge clk);
    bus.SS_n = 1'b1;
    @(negedge clk);
    check_output("abort_state", 32'(dut.state), 32'(IDLE));
    check_output("abort_rx_data", 32'(bus.rx_data), 32'h355);
    check_output("abort_rd_addr_seen", 32'(dut.rd_addr_seen), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("abort_no_valid", 32'(bus.rx_valid), 32'd0);
    end
    apply_stimulus(10'h3FF, 1'b0, -1);

    $display("[TB] spurious tx_valid during a write frame");
    apply_stimulus({WR_DATA, 8'hC3}, 1'b0, 4);
    @(negedge clk);
    check_output("spurious_miso", 32'(bus.MISO), 32'd0);

    repeat (3) @(negedge clk);
    check_output("rx_q_drained", 32'(rx_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
